bus_drive_sequencer: RTL and testbench

//  Upstream control/data stage for an octal inverting tri-state bus driver (74ABT540-type, two active-low OE pins).

---
 rtl/bus_drive_sequencer.sv | 132 +++++++++++++
 tb/tb_bus_drive_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_drive_sequencer.sv
// Control stage for an octal inverting tri-state bus driver: accepts a byte,
// waits for grant, inserts a turnaround gap, then drives A pins and both OE_n pins.
module bus_drive_sequencer #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             bus_grant,
  input  logic             abort,
  output logic [WIDTH-1:0] a_out,
  output logic             oe1_n,
  output logic             oe2_n,
  output logic             busy,
  output logic             done,
  output logic             lost_grant
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_GNT = 3'd1,
    S_TURN     = 3'd2,
    S_DRIVE    = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  localparam logic       NO_TURN   = (TURN_CYCLES == 0);
  localparam logic [3:0] TURN_INIT = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a_out;
  logic             r_oe_n;
  logic             r_busy;
  logic             r_done;
  logic             r_lost;

  // Transfer FSM; every output except req_ready is set on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_a_out <= {WIDTH{1'b1}};
      r_oe_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_lost <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_cnt   <= 4'd0;
        r_oe_n  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              r_a_out <= ~req_data;
              r_state <= S_WAIT_GNT;
              r_busy  <= 1'b1;
            end
          end
          S_WAIT_GNT: begin
            if (bus_grant) begin
              if (NO_TURN) begin
                r_state <= S_DRIVE;
                r_cnt   <= HOLD_INIT;
                r_oe_n  <= 1'b0;
              end else begin
                r_state <= S_TURN;
                r_cnt   <= TURN_INIT;
              end
            end
          end
          S_TURN: begin
            // Grant loss before driving just re-arms the wait; nothing was on the bus.
            if (!bus_grant) begin
              r_state <= S_WAIT_GNT;
              r_cnt   <= 4'd0;
            end else if (r_cnt == 4'd0) begin
              r_state <= S_DRIVE;
              r_cnt   <= HOLD_INIT;
              r_oe_n  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_DRIVE: begin
            if (!bus_grant) begin
              r_state <= S_RELEASE;
              r_cnt   <= 4'd0;
              r_oe_n  <= 1'b1;
              r_lost  <= 1'b1;
            end else if (r_cnt == 4'd0) begin
              r_state <= S_RELEASE;
              r_oe_n  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_RELEASE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_oe_n  <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign a_out      = r_a_out;
  assign oe1_n      = r_oe_n;
  assign oe2_n      = r_oe_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign lost_grant = r_lost;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Directed bench for bus_drive_sequencer (TURN=1, HOLD=2); expected values are
// hand-derived edge by edge, with outputs sampled 1 ns after each rising edge.
module tb_bus_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       bus_grant;
  logic       abort;
  logic [7:0] a_out;
  logic       oe1_n;
  logic       oe2_n;
  logic       busy;
  logic       done;
  logic       lost_grant;

  int n_tests = 0;
  int n_fail  = 0;

  bus_drive_sequencer #(.WIDTH(8), .TURN_CYCLES(1), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .bus_grant  (bus_grant),
    .abort      (abort),
    .a_out      (a_out),
    .oe1_n      (oe1_n),
    .oe2_n      (oe2_n),
    .busy       (busy),
    .done       (done),
    .lost_grant (lost_grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_oe(input string tag, input logic exp);
    check_eq({tag, "_oe1"}, 32'(oe1_n), 32'(exp));
    check_eq({tag, "_oe2"}, 32'(oe2_n), 32'(exp));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    bus_grant = 1'b0;
    abort     = 1'b0;
    tick();
    tick();
    check_eq("rst_a_out", 32'(a_out), 32'h0000_00FF);
    check_oe("rst", 1'b1);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_ready", 32'(req_ready), 32'd1);

    // Nominal transfer, grant already high
    bus_grant = 1'b1; req_valid = 1'b1; req_data = 8'h3C;
    tick(); // E0
    req_valid = 1'b0;
    check_eq("t1_a_out", 32'(a_out), 32'h0000_00C3);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_ready_e0", 32'(req_ready), 32'd0);
    check_oe("t1_e0", 1'b1);
    tick(); // E1
    check_oe("t1_e1", 1'b1);
    tick(); // E2
    check_oe("t1_e2", 1'b0);
    tick(); // E3
    check_oe("t1_e3", 1'b0);
    check_eq("t1_done_e3", 32'(done), 32'd0);
    tick(); // E4
    check_oe("t1_e4", 1'b1);
    check_eq("t1_done_e4", 32'(done), 32'd1);
    check_eq("t1_ready_e4", 32'(req_ready), 32'd0);
    tick(); // E5
    check_eq("t1_done_e5", 32'(done), 32'd0);
    check_eq("t1_ready_e5", 32'(req_ready), 32'd1);
    check_eq("t1_busy_e5", 32'(busy), 32'd0);
    check_eq("t1_a_hold", 32'(a_out), 32'h0000_00C3);

    // Grant arrives late
    bus_grant = 1'b0; req_valid = 1'b1; req_data = 8'h3C;
    tick(); // E0
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_oe($sformatf("t2_wait%0d", i), 1'b1);
      check_eq($sformatf("t2_busy%0d", i), 32'(busy), 32'd1);
    end
    bus_grant = 1'b1;
    tick();
    check_oe("t2_g1", 1'b1);
    tick();
    check_oe("t2_g2", 1'b0);
    tick();
    check_oe("t2_g3", 1'b0);
    tick();
    check_oe("t2_g4", 1'b1);
    check_eq("t2_done", 32'(done), 32'd1);
    tick();
    check_eq("t2_ready", 32'(req_ready), 32'd1);

    // Grant lost in first DRIVE cycle
    req_valid = 1'b1; req_data = 8'h55;
    tick(); // E0
    req_valid = 1'b0;
    check_eq("t3_a_out", 32'(a_out), 32'h0000_00AA);
    tick(); // E1
    tick(); // E2
    check_oe("t3_drive", 1'b0);
    bus_grant = 1'b0;
    tick(); // E3
    check_oe("t3_drop", 1'b1);
    check_eq("t3_lost", 32'(lost_grant), 32'd1);
    check_eq("t3_done_a", 32'(done), 32'd0);
    tick(); // E4
    check_eq("t3_lost_end", 32'(lost_grant), 32'd0);
    check_eq("t3_done_b", 32'(done), 32'd0);
    check_eq("t3_ready", 32'(req_ready), 32'd1);
    check_oe("t3_idle", 1'b1);
    bus_grant = 1'b1;

    // Abort during TURN
    req_valid = 1'b1; req_data = 8'h3C;
    tick(); // E0
    req_valid = 1'b0;
    tick(); // E1, now TURN
    abort = 1'b1;
    tick(); // E2
    abort = 1'b0;
    check_oe("t4_abort", 1'b1);
    check_eq("t4_ready", 32'(req_ready), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_a_out", 32'(a_out), 32'h0000_00C3);
    check_eq("t4_done", 32'(done), 32'd0);
    tick();
    check_eq("t4_done2", 32'(done), 32'd0);
    check_eq("t4_lost", 32'(lost_grant), 32'd0);
    check_oe("t4_after", 1'b1);

    // Reset mid-DRIVE
    req_valid = 1'b1; req_data = 8'h3C;
    tick(); // E0
    req_valid = 1'b0;
    tick(); // E1
    tick(); // E2
    check_oe("t5_drive", 1'b0);
    rst = 1'b1;
    tick(); // E3
    rst = 1'b0;
    check_oe("t5_rst", 1'b1);
    check_eq("t5_ready", 32'(req_ready), 32'd1);
    check_eq("t5_a_out", 32'(a_out), 32'h0000_00FF);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    tick();
    check_eq("t5_done2", 32'(done), 32'd0);

    // Back-to-back 0x01 then 0x80, valid held high
    req_valid = 1'b1; req_data = 8'h01;
    tick(); // E0
    req_data = 8'h80;
    check_eq("t6_a1", 32'(a_out), 32'h0000_00FE);
    tick(); // E1
    check_oe("t6_e1", 1'b1);
    tick(); // E2
    check_oe("t6_e2", 1'b0);
    tick(); // E3
    check_oe("t6_e3", 1'b0);
    check_eq("t6_a1_hold", 32'(a_out), 32'h0000_00FE);
    tick(); // E4
    check_oe("t6_e4", 1'b1);
    check_eq("t6_done1", 32'(done), 32'd1);
    tick(); // E5
    check_eq("t6_no_accept", 32'(a_out), 32'h0000_00FE);
    check_eq("t6_ready", 32'(req_ready), 32'd1);
    check_oe("t6_e5", 1'b1);
    tick(); // E6
    req_valid = 1'b0;
    check_eq("t6_a2", 32'(a_out), 32'h0000_007F);
    check_oe("t6_e6", 1'b1);
    tick(); // E7
    check_oe("t6_e7", 1'b1);
    tick(); // E8
    check_oe("t6_e8", 1'b0);
    tick(); // E9
    check_oe("t6_e9", 1'b0);
    tick(); // E10
    check_oe("t6_e10", 1'b1);
    check_eq("t6_done2", 32'(done), 32'd1);
    tick(); // E11
    check_eq("t6_ready2", 32'(req_ready), 32'd1);
    check_eq("t6_a2_hold", 32'(a_out), 32'h0000_007F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
